// File: rtl/cnn_layer_accel_rowbuf_monitor.sv
// Row-buffer output monitor placed beside one AWE.
// Each observed window word is compared against a per-channel expected-value
// FIFO that is loaded over a valid/ready port. The monitor keeps per-channel
// observation counts, a total mismatch count, a record of the first mismatch,
// sticky underflow flags and a done flag. All counters saturate at all-ones.
module cnn_layer_accel_rowbuf_monitor #(
   parameter int C_NUM_CH     = 2,
   parameter int C_DATA_WIDTH = 64,
   parameter int C_ROW_WIDTH  = 10,
   parameter int C_COL_WIDTH  = 10,
   parameter int C_EXP_DEPTH  = 16,
   parameter int C_CNT_WIDTH  = 16,
   localparam int C_CH_W      = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1
) (
   input  logic                             clk_core,
   input  logic                             rst,
   input  logic                             enable,
   input  logic                             clear,
   input  logic [1:0]                       mode,
   input  logic [C_NUM_CH-1:0]              obs_valid,
   input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] obs_data,
   input  logic [C_NUM_CH*C_ROW_WIDTH-1:0]  obs_row,
   input  logic [C_NUM_CH*C_COL_WIDTH-1:0]  obs_col,
   input  logic [C_NUM_CH-1:0]              obs_last,
   input  logic                             exp_valid,
   output logic                             exp_ready,
   input  logic [C_CH_W-1:0]                exp_chan,
   input  logic [C_DATA_WIDTH-1:0]          exp_data,
   input  logic [C_ROW_WIDTH-1:0]           exp_row,
   input  logic [C_COL_WIDTH-1:0]           exp_col,
   output logic [C_NUM_CH*C_CNT_WIDTH-1:0]  obs_cnt,
   output logic [C_CNT_WIDTH-1:0]           err_cnt,
   output logic                             first_err_valid,
   output logic [C_CH_W-1:0]                first_err_chan,
   output logic [C_ROW_WIDTH-1:0]           first_err_row,
   output logic [C_COL_WIDTH-1:0]           first_err_col,
   output logic [C_NUM_CH-1:0]              underflow,
   output logic                             done
);

   localparam int C_AW = $clog2(C_EXP_DEPTH);
   localparam logic [C_CNT_WIDTH-1:0] C_CNT_MAX = {C_CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_next;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [C_AW:0]             wr_ptr    [C_NUM_CH];
   logic [C_AW:0]             rd_ptr    [C_NUM_CH];
   logic [C_DATA_WIDTH-1:0]   fifo_data [C_NUM_CH][C_EXP_DEPTH];
   logic [C_ROW_WIDTH-1:0]    fifo_row  [C_NUM_CH][C_EXP_DEPTH];
   logic [C_COL_WIDTH-1:0]    fifo_col  [C_NUM_CH][C_EXP_DEPTH];

   logic [C_NUM_CH-1:0]       fifo_full, fifo_empty, empty_after;
   logic [C_NUM_CH-1:0]       push, pop, obs_acc, mismatch, underflow_set;
   logic [C_NUM_CH-1:0]       last_seen, last_next;
   logic                      full_sel, armed, check_mode, cmp_pos;
   logic                      all_last, all_drained;
   logic [C_CNT_WIDTH-1:0]    err_cnt_next;
   logic                      fe_hit;
   logic [C_CH_W-1:0]         fe_chan;
   logic [C_ROW_WIDTH-1:0]    fe_row;
   logic [C_COL_WIDTH-1:0]    fe_col;

   assign done = (state == S_DONE);

   // FIFO status and the combinational ready for the selected channel.
   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      full_sel = 1'b1;
      for (int i = 0; i < C_NUM_CH; i++) begin
         fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
         fifo_full[i]  = (wr_ptr[i][C_AW] != rd_ptr[i][C_AW]) &&
                         (wr_ptr[i][C_AW-1:0] == rd_ptr[i][C_AW-1:0]);
         if (exp_chan == C_CH_W'(i)) full_sel = fifo_full[i];
      end
      exp_ready = rst & (state != S_DONE) & ~full_sel;
   end

   // Per-channel push/pop, compare, underflow and completion terms.
   always_comb begin
      armed      = (state == S_ARMED);
      check_mode = (mode != 2'd2);
      cmp_pos    = (mode == 2'd1);
      for (int i = 0; i < C_NUM_CH; i++) begin
         obs_acc[i]       = armed & obs_valid[i];
         push[i]          = exp_valid & exp_ready & (exp_chan == C_CH_W'(i));
         pop[i]           = obs_acc[i] & check_mode & ~fifo_empty[i];
         underflow_set[i] = obs_acc[i] & check_mode & fifo_empty[i];
         mismatch[i]      = pop[i] &
            ((obs_data[i*C_DATA_WIDTH +: C_DATA_WIDTH] != fifo_data[i][rd_ptr[i][C_AW-1:0]]) |
             (cmp_pos &
              ((obs_row[i*C_ROW_WIDTH +: C_ROW_WIDTH] != fifo_row[i][rd_ptr[i][C_AW-1:0]]) |
               (obs_col[i*C_COL_WIDTH +: C_COL_WIDTH] != fifo_col[i][rd_ptr[i][C_AW-1:0]]))));
         empty_after[i]   = ((wr_ptr[i] + (C_AW+1)'(push[i])) == (rd_ptr[i] + (C_AW+1)'(pop[i])));
         last_next[i]     = last_seen[i] | (obs_acc[i] & obs_last[i]);
      end
      all_last    = &last_next;
      all_drained = ~check_mode | (&empty_after);
   end

   // Saturating error accumulation and lowest-index first-mismatch select.
   always_comb begin
      err_cnt_next = err_cnt;
      fe_hit       = 1'b0;
      fe_chan      = '0;
      fe_row       = '0;
      fe_col       = '0;
      for (int i = 0; i < C_NUM_CH; i++) begin
         if (mismatch[i] && err_cnt_next != C_CNT_MAX) err_cnt_next = err_cnt_next + C_CNT_WIDTH'(1);
      end
      for (int i = C_NUM_CH - 1; i >= 0; i--) begin
         if (mismatch[i]) begin
            fe_hit  = 1'b1;
            fe_chan = C_CH_W'(i);
            fe_row  = obs_row[i*C_ROW_WIDTH +: C_ROW_WIDTH];
            fe_col  = obs_col[i*C_COL_WIDTH +: C_COL_WIDTH];
         end
      end
   end

   // Next-state selection; DONE is left only through clear or reset.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (enable) state_next = S_ARMED;
         S_ARMED: begin
            if (!enable)                      state_next = S_IDLE;
            else if (all_last && all_drained) state_next = S_DONE;
         end
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   // Expected-value storage writes.
   // NOTE: the storage arrays are not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk_core) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
         if (push[i]) begin
            fifo_data[i][wr_ptr[i][C_AW-1:0]] <= exp_data;
            fifo_row[i][wr_ptr[i][C_AW-1:0]]  <= exp_row;
            fifo_col[i][wr_ptr[i][C_AW-1:0]]  <= exp_col;
         end
      end
   end

   // State, pointers, counters and sticky flags; reset and clear share one path.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_core) begin
      if (!rst || clear) begin
         state           <= S_IDLE;
         obs_cnt         <= '0;
         err_cnt         <= '0;
         first_err_valid <= 1'b0;
         first_err_chan  <= '0;
         first_err_row   <= '0;
         first_err_col   <= '0;
         underflow       <= '0;
         last_seen       <= '0;
         for (int i = 0; i < C_NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         state     <= state_next;
         err_cnt   <= err_cnt_next;
         underflow <= underflow | underflow_set;
         last_seen <= last_next;
         for (int i = 0; i < C_NUM_CH; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + (C_AW+1)'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (C_AW+1)'(1);
            if (obs_acc[i] && obs_cnt[i*C_CNT_WIDTH +: C_CNT_WIDTH] != C_CNT_MAX)
               obs_cnt[i*C_CNT_WIDTH +: C_CNT_WIDTH] <= obs_cnt[i*C_CNT_WIDTH +: C_CNT_WIDTH] + C_CNT_WIDTH'(1);
         end
         if (fe_hit && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_chan  <= fe_chan;
            first_err_row   <= fe_row;
            first_err_col   <= fe_col;
         end
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_rowbuf_monitor.sv
// Directed bench for the row-buffer monitor with the default two-channel
// configuration. Inputs change 1 ns after the rising edge and outputs are
// sampled at that same point, one edge after the stimulus cycle.
module tb_cnn_layer_accel_rowbuf_monitor;

   logic          clk_core = 1'b0;
   logic          rst, enable, clear;
   logic [1:0]    mode;
   logic [1:0]    obs_valid, obs_last;
   logic [127:0]  obs_data;
   logic [19:0]   obs_row, obs_col;
   logic          exp_valid, exp_ready;
   logic [0:0]    exp_chan;
   logic [63:0]   exp_data;
   logic [9:0]    exp_row, exp_col;
   logic [31:0]   obs_cnt;
   logic [15:0]   err_cnt;
   logic          first_err_valid;
   logic [0:0]    first_err_chan;
   logic [9:0]    first_err_row, first_err_col;
   logic [1:0]    underflow;
   logic          done;

   int checks = 0;
   int errors = 0;

   cnn_layer_accel_rowbuf_monitor dut (
      .clk_core(clk_core), .rst(rst), .enable(enable), .clear(clear), .mode(mode),
      .obs_valid(obs_valid), .obs_data(obs_data), .obs_row(obs_row), .obs_col(obs_col),
      .obs_last(obs_last), .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_chan(exp_chan),
      .exp_data(exp_data), .exp_row(exp_row), .exp_col(exp_col), .obs_cnt(obs_cnt),
      .err_cnt(err_cnt), .first_err_valid(first_err_valid), .first_err_chan(first_err_chan),
      .first_err_row(first_err_row), .first_err_col(first_err_col), .underflow(underflow),
      .done(done)
   );

   always #5 clk_core = ~clk_core;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   function automatic logic [63:0] dval(input int ch, input int k);
      return {48'hC0DE_0000_0000, 8'(ch), 8'(k)};
   endfunction

   task automatic push(input int ch, input logic [63:0] d, input logic [9:0] r, input logic [9:0] c);
      exp_valid = 1'b1;
      exp_chan  = ch[0];
      exp_data  = d;
      exp_row   = r;
      exp_col   = c;
      tick();
      exp_valid = 1'b0;
   endtask

   task automatic observe(input logic [1:0] v, input logic [1:0] last,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [9:0] r0, input logic [9:0] c0,
                          input logic [9:0] r1, input logic [9:0] c1);
      obs_valid = v;
      obs_last  = last;
      obs_data  = {d1, d0};
      obs_row   = {r1, r0};
      obs_col   = {c1, c0};
      tick();
      obs_valid = '0;
      obs_last  = '0;
   endtask

   // Four words per channel; channel 1 word 3 carries expected row 6 but is observed at row 5.
   task automatic run_row_case(input logic [1:0] m);
      enable = 1'b0;
      do_clear();
      for (int k = 0; k < 4; k++) begin
         push(0, dval(0, k), 10'(k), 10'(k));
         push(1, dval(1, k), (k == 3) ? 10'd6 : 10'(k), 10'(k));
      end
      mode   = m;
      enable = 1'b1;
      tick();
      for (int k = 0; k < 4; k++)
         observe(2'b11, (k == 3) ? 2'b11 : 2'b00, dval(0, k), dval(1, k),
                 10'(k), 10'(k), (k == 3) ? 10'd5 : 10'(k), 10'(k));
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; clear = 1'b0; mode = 2'd0;
      obs_valid = '0; obs_last = '0; obs_data = '0; obs_row = '0; obs_col = '0;
      exp_valid = 1'b1; exp_chan = '0; exp_data = '0; exp_row = '0; exp_col = '0;

      // Reset state
      tick(); tick();
      check("rst_exp_ready", exp_ready, 0);
      check("rst_obs_cnt", obs_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_done", done, 0);
      rst = 1'b1;
      exp_valid = 1'b0;

      // 1: four matching words per channel, last on the fourth
      for (int k = 0; k < 4; k++) begin
         push(0, dval(0, k), 10'(k), 10'(k));
         push(1, dval(1, k), 10'(k), 10'(k));
      end
      mode   = 2'd0;
      enable = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         observe(2'b11, (k == 3) ? 2'b11 : 2'b00, dval(0, k), dval(1, k), 10'(k), 10'(k), 10'(k), 10'(k));
         if (k == 2) check("t1_done_early", done, 0);
      end
      check("t1_obs_cnt", obs_cnt, 32'h0004_0004);
      check("t1_err_cnt", err_cnt, 0);
      check("t1_done", done, 1);
      check("t1_underflow", underflow, 0);
      check("t1_first_err_valid", first_err_valid, 0);
      exp_valid = 1'b1; exp_chan = 1'b0;
      #1;
      check("t1_ready_in_done", exp_ready, 0);
      exp_valid = 1'b0;

      // 2: row mismatch counts in mode 1 only
      run_row_case(2'd1);
      check("t2_m1_err_cnt", err_cnt, 1);
      check("t2_m1_fe_valid", first_err_valid, 1);
      check("t2_m1_fe_chan", first_err_chan, 1);
      check("t2_m1_fe_row", first_err_row, 5);
      check("t2_m1_fe_col", first_err_col, 3);
      check("t2_m1_done", done, 1);
      run_row_case(2'd0);
      check("t2_m0_err_cnt", err_cnt, 0);
      check("t2_m0_fe_valid", first_err_valid, 0);
      check("t2_m0_done", done, 1);

      // 3: simultaneous mismatches, lowest channel wins, record is sticky
      enable = 1'b0;
      do_clear();
      push(0, dval(0, 0), 10'd0, 10'd0);
      push(0, dval(0, 1), 10'd0, 10'd0);
      push(1, dval(1, 0), 10'd0, 10'd0);
      mode   = 2'd0;
      enable = 1'b1;
      tick();
      observe(2'b11, 2'b00, dval(0, 0) ^ 64'h1, dval(1, 0) ^ 64'h1, 10'd7, 10'd8, 10'd9, 10'd9);
      check("t3_err_cnt_2", err_cnt, 2);
      check("t3_fe_chan", first_err_chan, 0);
      check("t3_fe_row", first_err_row, 7);
      check("t3_fe_col", first_err_col, 8);
      observe(2'b01, 2'b00, dval(0, 1) ^ 64'h2, 64'h0, 10'd11, 10'd12, 10'd0, 10'd0);
      check("t3_err_cnt_3", err_cnt, 3);
      check("t3_fe_chan_hold", first_err_chan, 0);
      check("t3_fe_row_hold", first_err_row, 7);
      check("t3_fe_col_hold", first_err_col, 8);

      // 4: full FIFO rejects a push even with a same-cycle pop; then wrap traffic
      enable = 1'b0;
      do_clear();
      mode   = 2'd0;
      enable = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) push(0, 64'(k), 10'd0, 10'd0);
      exp_valid = 1'b1; exp_chan = 1'b0; exp_data = 64'd16;
      obs_valid = 2'b01; obs_data = {64'h0, 64'd0};
      #1;
      check("t4_ready_full", exp_ready, 0);
      tick();
      obs_valid = 2'b00;
      check("t4_ready_after_pop", exp_ready, 1);
      tick();
      exp_valid = 1'b0;
      observe(2'b01, 2'b00, 64'd1, 64'h0, 10'd0, 10'd0, 10'd0, 10'd0);
      for (int k = 0; k < 40; k++) begin
         exp_valid = 1'b1; exp_chan = 1'b0; exp_data = 64'(17 + k);
         obs_valid = 2'b01; obs_data = {64'h0, 64'(2 + k)};
         tick();
      end
      exp_valid = 1'b0; obs_valid = 2'b00;
      check("t4_err_cnt", err_cnt, 0);
      check("t4_underflow", underflow, 0);
      check("t4_obs_cnt", obs_cnt, 32'h0000_002A);

      // 5: underflow with a same-cycle push; the pushed entry stays queued
      enable = 1'b0;
      do_clear();
      mode   = 2'd0;
      enable = 1'b1;
      tick();
      exp_valid = 1'b1; exp_chan = 1'b1; exp_data = 64'hAB; exp_row = '0; exp_col = '0;
      obs_valid = 2'b10; obs_data = {64'hAB, 64'h0};
      tick();
      exp_valid = 1'b0; obs_valid = 2'b00;
      check("t5_underflow", underflow, 2'b10);
      check("t5_err_cnt", err_cnt, 0);
      check("t5_obs_cnt", obs_cnt, 32'h0001_0000);
      observe(2'b10, 2'b00, 64'h0, 64'hAC, 10'd0, 10'd0, 10'd0, 10'd0);
      check("t5_queued_entry_err", err_cnt, 1);
      check("t5_fe_chan", first_err_chan, 1);

      // 6: reset mid-stream, idle observations ignored, count-only mode, clear
      rst = 1'b0;
      obs_valid = 2'b11; exp_valid = 1'b1; exp_chan = 1'b0;
      tick();
      check("t6_rst_obs_cnt", obs_cnt, 0);
      check("t6_rst_err_cnt", err_cnt, 0);
      check("t6_rst_underflow", underflow, 0);
      check("t6_rst_fe_valid", first_err_valid, 0);
      check("t6_rst_fe_row", first_err_row, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_exp_ready", exp_ready, 0);
      enable = 1'b0;
      rst = 1'b1;
      exp_valid = 1'b0;
      tick();
      obs_valid = 2'b00;
      check("t6_idle_ignored", obs_cnt, 0);
      for (int k = 0; k < 16; k++) push(0, 64'(k), 10'd0, 10'd0);
      mode   = 2'd2;
      enable = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) observe(2'b01, 2'b00, 64'hFFFF, 64'h0, 10'd0, 10'd0, 10'd0, 10'd0);
      check("t6_m2_obs_cnt", obs_cnt, 32'h0000_0010);
      check("t6_m2_err_cnt", err_cnt, 0);
      check("t6_m2_underflow", underflow, 0);
      exp_valid = 1'b1; exp_chan = 1'b0;
      #1;
      check("t6_m2_no_pop", exp_ready, 0);
      exp_valid = 1'b0;
      observe(2'b11, 2'b11, 64'h0, 64'h0, 10'd0, 10'd0, 10'd0, 10'd0);
      check("t6_m2_done", done, 1);
      check("t6_m2_obs_cnt_last", obs_cnt, 32'h0001_0011);
      do_clear();
      check("t6_clear_obs_cnt", obs_cnt, 0);
      check("t6_clear_done", done, 0);
      exp_valid = 1'b1; exp_chan = 1'b0;
      #1;
      check("t6_clear_ready", exp_ready, 1);
      exp_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
